// File: rtl/timer_entry_loader.sv
// Keypad entry buffer for the microwave timer: shifts in up to NDIG digits, validates on START
// and issues a one-cycle active-low load strobe. Optional macro: TIMER_AUTO_NORMALIZE_EN.
module timer_entry_loader #(
   parameter int NDIG     = 3,
   parameter int MAX_TENS = 5
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] mins,
   output logic       loadn,
   output logic       busy,
   output logic       err,
   output logic [2:0] state_dbg
);

   // Handshake: key_valid is a one-cycle strobe with no ready; key_code is consumed on the
   // same rising edge, so a key is never stalled and keys arriving while busy are dropped.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_LOAD  = 3'd2,
      S_ARMED = 3'd3,
      S_NORM  = 3'd4
   } state_t;

   localparam logic [1:0] NDIG_C  = 2'(NDIG);
   localparam logic [3:0] MAX_T_C = 4'(MAX_TENS);

   state_t     state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic [3:0] ones_nxt, tens_nxt, mins_nxt;
   logic       err_nxt;
   logic       is_digit, is_cancel, is_start, all_zero;

   assign is_digit  = key_valid && (key_code <= 4'd9);
   assign is_cancel = key_valid && (key_code == 4'hA);
   assign is_start  = key_valid && (key_code == 4'hB);
   assign all_zero  = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (mins == 4'd0);
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ones_nxt  = sec_ones;
      tens_nxt  = sec_tens;
      mins_nxt  = mins;
      err_nxt   = 1'b0;
      if (is_cancel) begin
         state_nxt = S_IDLE;
         cnt_nxt   = 2'd0;
         ones_nxt  = 4'd0;
         tens_nxt  = 4'd0;
         mins_nxt  = 4'd0;
      end else begin
         case (state)
            S_IDLE, S_ENTRY: begin
               if (is_digit && (cnt < NDIG_C)) begin
                  mins_nxt  = sec_tens;
                  tens_nxt  = sec_ones;
                  ones_nxt  = key_code;
                  cnt_nxt   = cnt + 2'd1;
                  state_nxt = S_ENTRY;
               end else if (is_start) begin
                  if ((state == S_IDLE) || all_zero) begin
                     err_nxt = 1'b1;
                  end else if (sec_tens > MAX_T_C) begin
`ifdef TIMER_AUTO_NORMALIZE_EN
                     // Borrow a minute's worth of tens: e.g. 0:90 becomes 1:30.
                     if (mins < 4'd9) begin
                        mins_nxt  = mins + 4'd1;
                        tens_nxt  = sec_tens - 4'd6;
                        state_nxt = S_NORM;
                     end else begin
                        err_nxt = 1'b1;
                     end
`else
                     err_nxt = 1'b1;
`endif
                  end else begin
                     state_nxt = S_LOAD;
                  end
               end
            end
            S_NORM:  state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ARMED;
            S_ARMED: state_nxt = S_ARMED;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state    <= S_IDLE;
         cnt      <= 2'd0;
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         mins     <= 4'd0;
         loadn    <= 1'b1;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         sec_ones <= ones_nxt;
         sec_tens <= tens_nxt;
         mins     <= mins_nxt;
         // Strobe and busy follow the next state so they align with S_LOAD/S_ARMED.
         loadn    <= (state_nxt != S_LOAD);
         busy     <= (state_nxt == S_LOAD) || (state_nxt == S_ARMED);
         err      <= err_nxt;
      end
   end

endmodule

// File: tb/tb_timer_entry_loader.sv
// Directed bench for timer_entry_loader; snapshot is {mins,sec_tens,sec_ones,loadn,busy,err,state}.
module tb_timer_entry_loader;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ENTRY = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_ARMED = 3'd3;
   localparam logic [2:0] ST_NORM  = 3'd4;

   logic       clk;
   logic       clrn;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] sec_ones, sec_tens, mins;
   logic       loadn, busy, err;
   logic [2:0] state_dbg;
   logic [17:0] obs;

   int n_tests = 0;
   int n_fail  = 0;

   timer_entry_loader dut (
      .clk      (clk),
      .clrn     (clrn),
      .key_valid(key_valid),
      .key_code (key_code),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .mins     (mins),
      .loadn    (loadn),
      .busy     (busy),
      .err      (err),
      .state_dbg(state_dbg)
   );

   assign obs = {mins, sec_tens, sec_ones, loadn, busy, err, state_dbg};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a key for one rising edge; returns at the falling edge after it was sampled.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      clrn = 1'b0; key_valid = 1'b0; key_code = 4'h0;
      repeat (2) @(negedge clk);
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}) begin n_fail++; $display("FAIL reset_state got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}); end
      clrn = 1'b1;
      press(4'd1); press(4'd2);
      n_tests++; if (obs !== {4'd0,4'd1,4'd2,1'b1,1'b0,1'b0,ST_ENTRY}) begin n_fail++; $display("FAIL reset_pre_entry got %h exp %h", obs, {4'd0,4'd1,4'd2,1'b1,1'b0,1'b0,ST_ENTRY}); end
      #2 clrn = 1'b0;
      #1;
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}) begin n_fail++; $display("FAIL reset_async got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}); end
      @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic test_load();
      press(4'd1); press(4'd3); press(4'd0); press(4'hB);
      n_tests++; if (obs !== {4'd1,4'd3,4'd0,1'b0,1'b1,1'b0,ST_LOAD}) begin n_fail++; $display("FAIL load_strobe got %h exp %h", obs, {4'd1,4'd3,4'd0,1'b0,1'b1,1'b0,ST_LOAD}); end
      idle_cycle();
      n_tests++; if (obs !== {4'd1,4'd3,4'd0,1'b1,1'b1,1'b0,ST_ARMED}) begin n_fail++; $display("FAIL load_armed got %h exp %h", obs, {4'd1,4'd3,4'd0,1'b1,1'b1,1'b0,ST_ARMED}); end
      idle_cycle();
      n_tests++; if (obs !== {4'd1,4'd3,4'd0,1'b1,1'b1,1'b0,ST_ARMED}) begin n_fail++; $display("FAIL load_hold got %h exp %h", obs, {4'd1,4'd3,4'd0,1'b1,1'b1,1'b0,ST_ARMED}); end
      press(4'hA);
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}) begin n_fail++; $display("FAIL load_cancel got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}); end
   endtask

   task automatic test_saturate();
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      n_tests++; if (obs !== {4'd1,4'd2,4'd3,1'b1,1'b0,1'b0,ST_ENTRY}) begin n_fail++; $display("FAIL sat_fourth got %h exp %h", obs, {4'd1,4'd2,4'd3,1'b1,1'b0,1'b0,ST_ENTRY}); end
      press(4'hD); press(4'hF);
      n_tests++; if (obs !== {4'd1,4'd2,4'd3,1'b1,1'b0,1'b0,ST_ENTRY}) begin n_fail++; $display("FAIL sat_junk_key got %h exp %h", obs, {4'd1,4'd2,4'd3,1'b1,1'b0,1'b0,ST_ENTRY}); end
      press(4'hA);
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}) begin n_fail++; $display("FAIL sat_cancel got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}); end
   endtask

   task automatic test_tens_over();
      press(4'd0); press(4'd9); press(4'd0); press(4'hB);
`ifdef TIMER_AUTO_NORMALIZE_EN
      n_tests++; if (obs !== {4'd1,4'd3,4'd0,1'b1,1'b0,1'b0,ST_NORM}) begin n_fail++; $display("FAIL norm_cycle got %h exp %h", obs, {4'd1,4'd3,4'd0,1'b1,1'b0,1'b0,ST_NORM}); end
      idle_cycle();
      n_tests++; if (obs !== {4'd1,4'd3,4'd0,1'b0,1'b1,1'b0,ST_LOAD}) begin n_fail++; $display("FAIL norm_strobe got %h exp %h", obs, {4'd1,4'd3,4'd0,1'b0,1'b1,1'b0,ST_LOAD}); end
      idle_cycle();
      n_tests++; if (obs !== {4'd1,4'd3,4'd0,1'b1,1'b1,1'b0,ST_ARMED}) begin n_fail++; $display("FAIL norm_armed got %h exp %h", obs, {4'd1,4'd3,4'd0,1'b1,1'b1,1'b0,ST_ARMED}); end
`else
      n_tests++; if (obs !== {4'd0,4'd9,4'd0,1'b1,1'b0,1'b1,ST_ENTRY}) begin n_fail++; $display("FAIL tens_reject got %h exp %h", obs, {4'd0,4'd9,4'd0,1'b1,1'b0,1'b1,ST_ENTRY}); end
      idle_cycle();
      n_tests++; if (obs !== {4'd0,4'd9,4'd0,1'b1,1'b0,1'b0,ST_ENTRY}) begin n_fail++; $display("FAIL tens_err_width got %h exp %h", obs, {4'd0,4'd9,4'd0,1'b1,1'b0,1'b0,ST_ENTRY}); end
`endif
      press(4'hA);
      // 9 minutes cannot absorb another minute in either build
      press(4'd9); press(4'd9); press(4'd0); press(4'hB);
      n_tests++; if (obs !== {4'd9,4'd9,4'd0,1'b1,1'b0,1'b1,ST_ENTRY}) begin n_fail++; $display("FAIL tens_mins9 got %h exp %h", obs, {4'd9,4'd9,4'd0,1'b1,1'b0,1'b1,ST_ENTRY}); end
      press(4'hA);
      // boundary: sec_tens == 5 is legal
      press(4'd5); press(4'd9); press(4'hB);
      n_tests++; if (obs !== {4'd0,4'd5,4'd9,1'b0,1'b1,1'b0,ST_LOAD}) begin n_fail++; $display("FAIL tens_max_ok got %h exp %h", obs, {4'd0,4'd5,4'd9,1'b0,1'b1,1'b0,ST_LOAD}); end
      press(4'hA);
   endtask

   task automatic test_zero_start();
      press(4'hB);
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b1,ST_IDLE}) begin n_fail++; $display("FAIL zero_idle_start got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b1,ST_IDLE}); end
      press(4'd0); press(4'd0);
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_ENTRY}) begin n_fail++; $display("FAIL zero_digits got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_ENTRY}); end
      press(4'hB);
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b1,ST_ENTRY}) begin n_fail++; $display("FAIL zero_entry_start got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b1,ST_ENTRY}); end
      // leading zeros counted: one more digit fills, the next is dropped
      press(4'd7); press(4'd8);
      n_tests++; if (obs !== {4'd0,4'd0,4'd7,1'b1,1'b0,1'b0,ST_ENTRY}) begin n_fail++; $display("FAIL zero_leading_cnt got %h exp %h", obs, {4'd0,4'd0,4'd7,1'b1,1'b0,1'b0,ST_ENTRY}); end
      press(4'hA);
   endtask

   task automatic test_armed_ignore();
      press(4'd5); press(4'd4); press(4'd5); press(4'hB);
      idle_cycle();
      press(4'd7);
      n_tests++; if (obs !== {4'd5,4'd4,4'd5,1'b1,1'b1,1'b0,ST_ARMED}) begin n_fail++; $display("FAIL armed_digit got %h exp %h", obs, {4'd5,4'd4,4'd5,1'b1,1'b1,1'b0,ST_ARMED}); end
      press(4'hB);
      n_tests++; if (obs !== {4'd5,4'd4,4'd5,1'b1,1'b1,1'b0,ST_ARMED}) begin n_fail++; $display("FAIL armed_start got %h exp %h", obs, {4'd5,4'd4,4'd5,1'b1,1'b1,1'b0,ST_ARMED}); end
      press(4'hA);
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}) begin n_fail++; $display("FAIL armed_cancel got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}); end
   endtask

   task automatic test_cancel_in_load();
      press(4'd2); press(4'd0); press(4'd0); press(4'hB);
      n_tests++; if (obs !== {4'd2,4'd0,4'd0,1'b0,1'b1,1'b0,ST_LOAD}) begin n_fail++; $display("FAIL cl_strobe got %h exp %h", obs, {4'd2,4'd0,4'd0,1'b0,1'b1,1'b0,ST_LOAD}); end
      press(4'hA);
      n_tests++; if (obs !== {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}) begin n_fail++; $display("FAIL cl_abort got %h exp %h", obs, {4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,ST_IDLE}); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_saturate();
      test_tens_over();
      test_zero_start();
      test_armed_ignore();
      test_cancel_in_load();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
